prep_window_ctrl: RTL and testbench

//  Sequencer for the PreparationModule line-buffer chain (ROWS-1 cascaded row delays plus live row).

---
 rtl/prep_window_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_prep_window_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prep_window_ctrl.sv
// Sequencer for a line-buffer window chain: counts pixels, drives the shift enable, flags centred
// windows and drains the chain with zero rows at frame end. Optional border flags: PREP_WCTRL_BORDER_EN.
//
// state  | meaning
// IDLE   | waiting for the first pixel of a frame
// FILL   | priming the top HALF rows, no windows yet
// ACTIVE | every accepted pixel yields a centred window
// FLUSH  | shifting zero pixels to drain the chain
// DONE   | frame finished, counters cleared
module prep_window_ctrl #(
   parameter int WIDTH = 17,
   parameter int ROWS  = 17,
   parameter int ROW_W = 10,
   parameter int COL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             done_i,
   output logic             lb_en_o,
   output logic             pad_o,
   output logic             window_valid_o,
   output logic [ROW_W-1:0] out_row_o,
   output logic [COL_W-1:0] out_col_o,
   output logic [3:0]       border_o,
   output logic             frame_done_o,
   output logic             err_o
);

   localparam int HALF = (ROWS - 1) / 2;
   localparam int FL_W = $clog2((HALF + 1) * WIDTH + 1);
   localparam logic [ROW_W-1:0] HALF_R = ROW_W'(HALF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ACTIVE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t           state;
   logic [COL_W-1:0] in_col;
   logic [ROW_W-1:0] in_row;
   logic [FL_W-1:0]  flush_cnt;

   logic             accepting;
   logic             col_wrap;
   logic             row_sat;
   logic             row_ovf;
   logic             shift_win;
   logic             flush_go;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;
   logic [FL_W-1:0]  flush_len;

   assign accepting = (state == S_IDLE) | (state == S_FILL) | (state == S_ACTIVE);
   assign lb_en_o   = (valid_i & accepting) | (state == S_FLUSH);
   assign pad_o     = (state == S_FLUSH);
   assign col_wrap  = (in_col == COL_W'(WIDTH - 1));
   assign row_sat   = (in_row == {ROW_W{1'b1}});
   assign shift_win = lb_en_o & (in_row >= HALF_R);

   // A done pulse in IDLE with a pixel alongside still counts as a (one-pixel) frame.
   assign flush_go  = done_i & ((state == S_FILL) | (state == S_ACTIVE) |
                                ((state == S_IDLE) & valid_i));

   always_comb begin
      col_nxt = in_col;
      row_nxt = in_row;
      row_ovf = 1'b0;
      if (lb_en_o) begin
         if (col_wrap) begin
            col_nxt = '0;
            if (row_sat) begin
               row_ovf = 1'b1;
            end else begin
               row_nxt = in_row + ROW_W'(1);
            end
         end else begin
            col_nxt = in_col + COL_W'(1);
         end
      end
      // Pad out a partial last row, then HALF full zero rows to centre the bottom rows.
      flush_len = FL_W'(HALF * WIDTH);
      if (col_nxt != '0) begin
         flush_len = FL_W'(HALF * WIDTH) + FL_W'(WIDTH) - FL_W'(col_nxt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         in_col         <= '0;
         in_row         <= '0;
         flush_cnt      <= '0;
         window_valid_o <= 1'b0;
         out_row_o      <= '0;
         out_col_o      <= '0;
         frame_done_o   <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         window_valid_o <= shift_win;
         if (shift_win) begin
            out_row_o <= in_row - HALF_R;
            out_col_o <= in_col;
         end
         frame_done_o <= (state == S_DONE);
         in_col       <= col_nxt;
         in_row       <= row_nxt;

         if (row_ovf) begin
            err_o <= 1'b1;
         end
         if (valid_i & ((state == S_FLUSH) | (state == S_DONE))) begin
            err_o <= 1'b1;
         end

         if (flush_go) begin
            state     <= S_FLUSH;
            flush_cnt <= flush_len;
            if (col_nxt != '0) begin
               err_o <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (done_i) begin
                     state <= S_DONE;
                  end else if (valid_i) begin
                     state <= S_FILL;
                  end
               end
               S_FILL: begin
                  if (row_nxt >= HALF_R) begin
                     state <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  state <= S_ACTIVE;
               end
               S_FLUSH: begin
                  flush_cnt <= flush_cnt - FL_W'(1);
                  if (flush_cnt == FL_W'(1)) begin
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  in_col <= '0;
                  in_row <= '0;
                  state  <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef PREP_WCTRL_BORDER_EN
   // pad_row marks that the current flush row is entirely padding (below the image).
   logic pad_row;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_row  <= 1'b0;
         border_o <= 4'b0000;
      end else begin
         if (flush_go) begin
            pad_row <= (col_nxt == '0);
         end else if ((state == S_FLUSH) && col_wrap) begin
            pad_row <= 1'b1;
         end else if (state == S_DONE) begin
            pad_row <= 1'b0;
         end
         if (shift_win) begin
            border_o <= {((in_row - HALF_R) < HALF_R),
                         (pad_o & pad_row),
                         (in_col < COL_W'(HALF)),
                         (in_col >= COL_W'(WIDTH - HALF))};
         end
      end
   end
`else
   assign border_o = 4'b0000;
`endif

endmodule

// File: tb/tb_prep_window_ctrl.sv
// Directed bench for prep_window_ctrl (WIDTH=17, ROWS=17): table of whole-frame scenarios plus
// hand-written reset, idle-done and border sequences.
module tb_prep_window_ctrl;

   localparam int WIDTH = 17;
   localparam int ROWS  = 17;
   localparam int ROW_W = 10;
   localparam int COL_W = 5;

   logic             clk;
   logic             rst;
   logic             valid_i;
   logic             done_i;
   logic             lb_en_o;
   logic             pad_o;
   logic             window_valid_o;
   logic [ROW_W-1:0] out_row_o;
   logic [COL_W-1:0] out_col_o;
   logic [3:0]       border_o;
   logic             frame_done_o;
   logic             err_o;

   prep_window_ctrl #(.WIDTH(WIDTH), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
      .clk(clk),
      .rst(rst),
      .valid_i(valid_i),
      .done_i(done_i),
      .lb_en_o(lb_en_o),
      .pad_o(pad_o),
      .window_valid_o(window_valid_o),
      .out_row_o(out_row_o),
      .out_col_o(out_col_o),
      .border_o(border_o),
      .frame_done_o(frame_done_o),
      .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchecks = 0;
   int nerr    = 0;

   // monitor state, written only by the monitor process
   logic mon_clr;
   int   win_cnt, shift_cnt, pad_cnt, fd_cnt, seq_bad, win_noshift, first_shift;
   int   exp_r, exp_c, last_r, last_c, last_win_cyc, fd_cyc, cyc;
   logic prev_lb;
   logic [3:0] b00, b88, blast, border_or;

   always @(negedge clk) begin
      if (mon_clr) begin
         win_cnt = 0; shift_cnt = 0; pad_cnt = 0; fd_cnt = 0; seq_bad = 0;
         win_noshift = 0; first_shift = -1; exp_r = 0; exp_c = 0;
         last_r = -1; last_c = -1; last_win_cyc = -1; fd_cyc = -1; cyc = 0;
         prev_lb = 1'b0; b00 = 4'hf; b88 = 4'hf; blast = 4'hf; border_or = 4'h0;
      end else begin
         if (window_valid_o) begin
            if (!prev_lb) win_noshift++;
            if (win_cnt == 0) first_shift = shift_cnt;
            if (int'(out_row_o) != exp_r || int'(out_col_o) != exp_c) seq_bad++;
            if (out_row_o == 0 && out_col_o == 0) b00 = border_o;
            if (out_row_o == 8 && out_col_o == 8) b88 = border_o;
            blast = border_o;
            border_or = border_or | border_o;
            last_r = int'(out_row_o);
            last_c = int'(out_col_o);
            last_win_cyc = cyc;
            win_cnt++;
            exp_c++;
            if (exp_c == WIDTH) begin
               exp_c = 0;
               exp_r++;
            end
         end
         if (lb_en_o) shift_cnt++;
         prev_lb = lb_en_o;
         if (pad_o) pad_cnt++;
         if (frame_done_o) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         cyc++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_i = 1'b0; done_i = 1'b0; mon_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 mon_clr = 1'b0;
   endtask

   // mode 0: continuous; 1: random 50% valid; 2: continuous with done on the last pixel
   task automatic drive_pixels(input int npix, input int mode);
      int  i;
      bit  v;
      i = 0;
      while (i < npix) begin
         v = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
         valid_i = v;
         done_i  = (mode == 2) && v && (i == npix - 1);
         @(posedge clk);
         #1;
         if (v) i++;
      end
      valid_i = 1'b0;
      done_i  = 1'b0;
      if (mode != 2) begin
         done_i = 1'b1;
         @(posedge clk);
         #1 done_i = 1'b0;
      end
   endtask

   task automatic wait_frame_done(input string name, input bit flush_valid);
      int k;
      k = 0;
      while (k < 1000 && fd_cnt == 0) begin
         valid_i = flush_valid && (k >= 3) && (k < 9);
         @(posedge clk);
         #1;
         k++;
      end
      valid_i = 1'b0;
      if (fd_cnt == 0) begin
         nchecks++;
         nerr++;
         $display("FAIL %s_timeout: got no frame_done expected pulse within 1000 cycles", name);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      string name;
      int    npix;
      int    mode;
      bit    flush_valid;
      int    exp_win;
      int    exp_flush;
      int    exp_err;
      int    exp_last_r;
      int    exp_last_c;
      int    exp_first;
   } vec_t;

   vec_t vecs[5];
   int   bad;

   initial begin
      vecs[0] = '{"full_cont",   289, 0, 1'b0, 289, 136, 0, 16, 16, 137};
      vecs[1] = '{"full_rand",   289, 1, 1'b0, 289, 136, 0, 16, 16, 137};
      vecs[2] = '{"partial_r5",   88, 0, 1'b0, 102, 150, 1,  5, 16, 137};
      vecs[3] = '{"valid_flush", 289, 0, 1'b1, 289, 136, 1, 16, 16, 137};
      vecs[4] = '{"done_same",   289, 2, 1'b0, 289, 136, 0, 16, 16, 137};

      // reset values and quiet idle
      do_reset();
      chk("rst_window_valid", int'(window_valid_o), 0);
      chk("rst_out_row", int'(out_row_o), 0);
      chk("rst_out_col", int'(out_col_o), 0);
      chk("rst_border", int'(border_o), 0);
      chk("rst_frame_done", int'(frame_done_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_lb_en", int'(lb_en_o), 0);
      chk("rst_pad", int'(pad_o), 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (lb_en_o || pad_o || window_valid_o || frame_done_o || err_o || border_o != 0 ||
             out_row_o != 0 || out_col_o != 0) bad++;
      end
      chk("idle_100_quiet", bad, 0);

      // scenario table
      for (int t = 0; t < 5; t++) begin
         do_reset();
         drive_pixels(vecs[t].npix, vecs[t].mode);
         wait_frame_done(vecs[t].name, vecs[t].flush_valid);
         chk({vecs[t].name, "_windows"}, win_cnt, vecs[t].exp_win);
         chk({vecs[t].name, "_flush"}, pad_cnt, vecs[t].exp_flush);
         chk({vecs[t].name, "_err"}, int'(err_o), vecs[t].exp_err);
         chk({vecs[t].name, "_last_row"}, last_r, vecs[t].exp_last_r);
         chk({vecs[t].name, "_last_col"}, last_c, vecs[t].exp_last_c);
         chk({vecs[t].name, "_first_after"}, first_shift, vecs[t].exp_first);
         chk({vecs[t].name, "_seq"}, seq_bad, 0);
         chk({vecs[t].name, "_win_no_shift"}, win_noshift, 0);
         chk({vecs[t].name, "_frame_done_cnt"}, fd_cnt, 1);
         chk({vecs[t].name, "_frame_done_lag"}, fd_cyc - last_win_cyc, 1);
         if (t == 0) begin
`ifdef PREP_WCTRL_BORDER_EN
            chk("border_0_0", int'(b00), 4'b1010);
            chk("border_8_8", int'(b88), 4'b0000);
            chk("border_16_16", int'(blast), 4'b0101);
`else
            chk("border_all_zero", int'(border_or), 0);
`endif
         end
      end

      // done with no pixels
      do_reset();
      done_i = 1'b1;
      @(posedge clk);
      #1 done_i = 1'b0;
      wait_frame_done("idle_done", 1'b0);
      chk("idle_done_windows", win_cnt, 0);
      chk("idle_done_fd", fd_cnt, 1);
      chk("idle_done_pad", pad_cnt, 0);
      chk("idle_done_err", int'(err_o), 0);

      // reset mid-ACTIVE, then a clean frame
      do_reset();
      valid_i = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      rst = 1'b1;
      valid_i = 1'b0;
      #1;
      chk("midrst_window_valid", int'(window_valid_o), 0);
      chk("midrst_out_row", int'(out_row_o), 0);
      chk("midrst_lb_en", int'(lb_en_o), 0);
      chk("midrst_err", int'(err_o), 0);
      do_reset();
      drive_pixels(289, 0);
      wait_frame_done("after_rst", 1'b0);
      chk("after_rst_windows", win_cnt, 289);
      chk("after_rst_seq", seq_bad, 0);
      chk("after_rst_last_row", last_r, 16);
      chk("after_rst_err", int'(err_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
